reflet_uart_rx_fifo: RTL and testbench

Serial receiver for the far end of a `reflet_uart` TX line: it deserialises 8N1 frames, buffers received bytes in a small FIFO, and presents them as a valid/ready byte stream. It sits outside the CPU bus. Simulation benches use it to capture and check what firmware prints. SoC tops use it as a byte source for peripherals that consume the serial stream.

---
 rtl/reflet_uart_rx_fifo_pkg.sv | 19 +
 rtl/reflet_fifo_sync.sv | 56 +++++
 rtl/reflet_uart_rx_fifo.sv | 141 ++++++++++++++
 tb/tb_reflet_uart_rx_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_uart_rx_fifo_pkg.sv
// rtl/reflet_uart_rx_fifo_pkg.sv - shared reflet_uart frame constants and receive state encoding
package reflet_uart_rx_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } rx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   function automatic int bit_period(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/reflet_fifo_sync.sv
// rtl/reflet_fifo_sync.sv - synchronous first-word-fall-through FIFO
// Head entry is visible on dout whenever the FIFO is non-empty; dout reads 0 when empty.
module reflet_fifo_sync #(
   parameter int width = 8,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [width-1:0]         din,
   output logic [width-1:0]         dout,
   output logic [$clog2(depth):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(depth);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(depth);

   if ((depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
      $error("reflet_fifo_sync: depth must be a power of two and at least 2");
   end

   logic [width-1:0] r_mem [depth];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_level;
   logic             w_do_pop;
   logic             w_do_push;

   assign empty     = (r_level == '0);
   assign full      = (r_level == LVL_FULL);
   assign level     = r_level;
   assign dout      = empty ? '0 : r_mem[r_rd_ptr];
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= r_level + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
   end

endmodule

// File: rtl/reflet_uart_rx_fifo.sv
// rtl/reflet_uart_rx_fifo.sv - 8N1 serial receiver feeding a FWFT byte FIFO
// Sticky overflow/frame_error flags; set beats clear_errors in the same cycle.
module reflet_uart_rx_fifo
   import reflet_uart_rx_fifo_pkg::*;
#(
   parameter int clk_freq   = 96000,
   parameter int baud_rate  = 9600,
   parameter int fifo_depth = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rx,
   output logic [7:0]                   data_out,
   output logic                         data_valid,
   input  logic                         data_ready,
   output logic [$clog2(fifo_depth):0]  level,
   output logic                         overflow,
   output logic                         frame_error,
   input  logic                         clear_errors
);

   localparam int P  = bit_period(clk_freq, baud_rate);
   localparam int CW = $clog2(P);
   localparam logic [CW-1:0] CNT_HALF = CW'(P / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

   if ((P < 4) || (STOP_BITS != 1)) begin : g_bad_period
      $error("reflet_uart_rx_fifo: bit period clk_freq/baud_rate must be at least 4");
   end

   logic            r_sync1;
   logic            r_sync2;
   rx_state_t       r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_index;
   logic [7:0]      r_data;
   logic            r_overflow;
   logic            r_frame_error;
   logic            w_rxs;
   logic            w_stop_sample;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;

   assign w_rxs         = r_sync2;
   assign w_stop_sample = (r_state == ST_STOP) && (r_cnt == CNT_LAST);
   assign w_push        = w_stop_sample && w_rxs;
   assign w_pop         = data_valid && data_ready;
   assign data_valid    = !w_empty;
   assign overflow      = r_overflow;
   assign frame_error   = r_frame_error;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_index <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt   <= '0;
               r_index <= '0;
               // The cycle that first sees rxs low is count 0 of the start bit.
               if (!w_rxs) begin
                  r_state <= ST_START;
                  r_cnt   <= CW'(1);
               end
            end
            ST_START: begin
               if (r_cnt == CNT_HALF) begin
                  r_cnt   <= '0;
                  r_state <= w_rxs ? ST_IDLE : ST_DATA;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt           <= '0;
                  r_data[r_index] <= w_rxs;
                  r_index         <= r_index + 3'd1;
                  if (r_index == IDX_LAST) r_state <= ST_STOP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_STOP: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= w_rxs ? ST_IDLE : ST_WAIT_HIGH;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_WAIT_HIGH: begin
               if (w_rxs) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow    <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_overflow    <= (w_push && w_full && !w_pop) || (r_overflow && !clear_errors);
         r_frame_error <= (w_stop_sample && !w_rxs) || (r_frame_error && !clear_errors);
      end
   end

   reflet_fifo_sync #(
      .width (8),
      .depth (fifo_depth)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (data_ready),
      .din   (r_data),
      .dout  (data_out),
      .level (level),
      .full  (w_full),
      .empty (w_empty)
   );

endmodule

// File: tb/tb_reflet_uart_rx_fifo.sv
// tb/tb_reflet_uart_rx_fifo.sv - self-checking bench for reflet_uart_rx_fifo
module tb_reflet_uart_rx_fifo;

   localparam int P = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       data_ready = 1'b0;
   logic       clear_errors = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic [3:0] level;
   logic       overflow;
   logic       frame_error;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   rise_cyc = -1;
   int   c0 = 0;
   bit   rnd_mode = 1'b0;
   logic dv_prev = 1'b0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_n;
      logic       exp_ferr;
   } vec_t;
   vec_t vt[8];

   always #5 clk = ~clk;

   reflet_uart_rx_fifo #(
      .clk_freq   (96000),
      .baud_rate  (9600),
      .fifo_depth (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .level        (level),
      .overflow     (overflow),
      .frame_error  (frame_error),
      .clear_errors (clear_errors)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer side: every accepted byte is captured, and the first rise of data_valid is time-stamped.
   always @(negedge clk) begin
      if (!reset && data_valid && data_ready) got.push_back(data_out);
      if (data_valid && !dv_prev && rise_cyc < 0) rise_cyc = cyc;
      dv_prev = data_valid;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rnd_mode) data_ready = 1'($urandom_range(0, 1));
      end
   endtask

   // Drives one 8N1 frame bit by bit; stops early (line back high) after 'cut' cycles.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int cut);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int k = 0; k < 10 * P && k < cut; k++) begin
         rx = f[k / P];
         tick(1);
      end
      rx = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b1, 10 * P);
   endtask

   task automatic check_stream(input string name);
      chk({name, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk(name, (i < got.size()) ? int'(got[i]) : -1, int'(exp_q[i]));
   endtask

   task automatic clear_flags();
      clear_errors = 1'b1;
      tick(1);
      clear_errors = 1'b0;
   endtask

   initial begin
      string      msg;
      logic [7:0] b;
      logic       good;
      logic       exp_ferr;

      vt[0] = '{8'h00, 1'b1, 1, 1'b0};
      vt[1] = '{8'hFF, 1'b1, 1, 1'b0};
      vt[2] = '{8'hA5, 1'b1, 1, 1'b0};
      vt[3] = '{8'h5A, 1'b1, 1, 1'b0};
      vt[4] = '{8'h01, 1'b1, 1, 1'b0};
      vt[5] = '{8'h80, 1'b1, 1, 1'b0};
      vt[6] = '{8'h55, 1'b0, 0, 1'b1};
      vt[7] = '{8'hC3, 1'b1, 1, 1'b0};

      tick(3);
      chk("rst_valid", data_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_data", data_out, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ferr", frame_error, 0);
      reset = 1'b0;
      tick(2);

      // Single byte: latency from the rx falling edge to data_valid.
      rise_cyc = -1;
      c0 = cyc;
      send(8'h48);
      tick(2);
      chk("t1_latency", rise_cyc - c0, 98);
      chk("t1_data", data_out, 8'h48);
      chk("t1_level", level, 1);
      data_ready = 1'b1;
      tick(1);
      data_ready = 1'b0;
      chk("t1_pop_level", level, 0);
      chk("t1_pop_data", data_out, 0);
      chk("t1_pop_valid", data_valid, 0);

      // Vector table of single frames.
      data_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         got.delete();
         send_frame(vt[i].data, vt[i].stop, 10 * P);
         tick(P);
         chk("vec_count", got.size(), vt[i].exp_n);
         if (vt[i].exp_n == 1 && got.size() > 0) chk("vec_data", got[0], vt[i].data);
         chk("vec_ferr", frame_error, vt[i].exp_ferr);
         clear_flags();
      end

      // Back-to-back message stream.
      got.delete();
      exp_q.delete();
      msg = "Hello, world!";
      for (int i = 0; i < msg.len(); i++) begin
         exp_q.push_back(msg[i]);
         send(msg[i]);
      end
      tick(5);
      check_stream("t2_msg");
      chk("t2_ovf", overflow, 0);
      chk("t2_ferr", frame_error, 0);

      // Overflow: ten bytes into an eight-entry FIFO with no consumer.
      data_ready = 1'b0;
      got.delete();
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
         send(8'(i));
         if (i < 8) exp_q.push_back(8'(i));
      end
      tick(3);
      chk("t3_level", level, 8);
      chk("t3_ovf", overflow, 1);
      data_ready = 1'b1;
      tick(12);
      data_ready = 1'b0;
      check_stream("t3_drain");
      clear_flags();
      chk("t3_ovf_clr", overflow, 0);

      // Framing error followed by a line held low (break), then a clean frame.
      data_ready = 1'b1;
      got.delete();
      send_frame(8'h55, 1'b0, 10 * P);
      rx = 1'b0;
      tick(3 * P);
      rx = 1'b1;
      tick(P);
      chk("t4_ferr", frame_error, 1);
      chk("t4_nopush", got.size(), 0);
      exp_q.delete();
      exp_q.push_back(8'hA5);
      send(8'hA5);
      tick(3);
      check_stream("t4_after");
      clear_flags();

      // False start: three-cycle glitch.
      got.delete();
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(2 * P);
      chk("t5_nopush", got.size(), 0);
      chk("t5_level", level, 0);
      exp_q.delete();
      exp_q.push_back(8'h3C);
      send(8'h3C);
      tick(3);
      check_stream("t5_after");

      // Reset in the middle of data bit 4 with two bytes buffered.
      data_ready = 1'b0;
      got.delete();
      send(8'h21);
      send(8'h22);
      tick(3);
      chk("t6_level_pre", level, 2);
      send_frame(8'h7E, 1'b1, 5 * P + 3);
      reset = 1'b1;
      tick(1);
      chk("t6_level", level, 0);
      chk("t6_valid", data_valid, 0);
      chk("t6_data", data_out, 0);
      chk("t6_ovf", overflow, 0);
      chk("t6_ferr", frame_error, 0);
      reset = 1'b0;
      tick(P);
      data_ready = 1'b1;
      exp_q.delete();
      exp_q.push_back(8'h11);
      send(8'h11);
      tick(3);
      check_stream("t6_after");

      // Random frames, random stop-bit faults, random gaps and a random consumer.
      got.delete();
      exp_q.delete();
      exp_ferr = 1'b0;
      rnd_mode = 1'b1;
      for (int n = 0; n < 16; n++) begin
         b = 8'($urandom);
         good = ($urandom_range(0, 4) != 0);
         send_frame(b, good, 10 * P);
         if (good) begin
            exp_q.push_back(b);
            tick($urandom_range(0, P));
         end else begin
            exp_ferr = 1'b1;
            tick(P);
         end
      end
      rnd_mode = 1'b0;
      data_ready = 1'b1;
      tick(20);
      check_stream("rnd");
      chk("rnd_ferr", frame_error, exp_ferr);
      chk("rnd_ovf", overflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
